// File: rtl/stdmacro_dffe_pipe.sv
// Elastic register pipeline with per-stage valid bits, bubble collapse and flush.
// Stage data registers are enable-gated so bubbles never disturb the data path.
module stdmacro_dffe_pipe #(
  parameter int                   DFF_WIDTH       = 1,
  parameter logic [DFF_WIDTH-1:0] DFF_RESET_VALUE = '0,
  parameter int                   PIPE_DEPTH      = 2,
  localparam int                  CW              = $clog2(PIPE_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 flush,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DFF_WIDTH-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DFF_WIDTH-1:0] m_data,
  output logic [CW-1:0]        count
);

  logic [PIPE_DEPTH-1:0] v;
  logic [PIPE_DEPTH-1:0] v_nxt;
  logic [PIPE_DEPTH-1:0] in_v;
  logic [PIPE_DEPTH-1:0] rdy;
  logic [PIPE_DEPTH-1:0] d_en;
  logic                  rdy_acc;
  logic [CW-1:0]         cnt_nxt;
  logic [DFF_WIDTH-1:0]  d [PIPE_DEPTH];

  // Readiness ripples from the output side back toward the input.
  always_comb begin
    rdy     = '0;
    rdy_acc = !v[PIPE_DEPTH-1] || m_ready;
    rdy[PIPE_DEPTH-1] = rdy_acc;
    for (int i = PIPE_DEPTH - 2; i >= 0; i--) begin
      rdy_acc = !v[i] || rdy_acc;
      rdy[i]  = rdy_acc;
    end
  end

  always_comb begin
    in_v    = '0;
    v_nxt   = '0;
    d_en    = '0;
    cnt_nxt = '0;
    in_v[0] = s_valid;
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      in_v[i] = v[i-1];
    end
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      v_nxt[i] = flush ? 1'b0 : (rdy[i] ? in_v[i] : v[i]);
      d_en[i]  = rdy[i] && !flush && in_v[i];
      cnt_nxt  = cnt_nxt + CW'(v_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      v     <= '0;
      count <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        d[i] <= DFF_RESET_VALUE;
      end
    end else begin
      v     <= v_nxt;
      count <= cnt_nxt;
      if (d_en[0]) d[0] <= s_data;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        if (d_en[i]) d[i] <= d[i-1];
      end
    end
  end

  assign s_ready = rdy[0] && !flush;
  assign m_valid = v[PIPE_DEPTH-1] && !flush;
  assign m_data  = d[PIPE_DEPTH-1];

endmodule

// File: tb/tb_stdmacro_dffe_pipe.sv
// Directed bench for stdmacro_dffe_pipe: W=8, depth 3, reset value 8'hA5.
module tb_stdmacro_dffe_pipe;

  logic       clk;
  logic       clk_en;
  logic       aresetn;
  logic       flush;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] count;

  int checks;
  int errors;

  stdmacro_dffe_pipe #(
    .DFF_WIDTH       (8),
    .DFF_RESET_VALUE (8'hA5),
    .PIPE_DEPTH      (3)
  ) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .flush   (flush),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    clk_en  = 1'b0;
    aresetn = 1'b1;
    flush   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b0;

    // reset with the clock stopped
    #1 aresetn = 1'b0;
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_count",   32'(count),   32'd0);
    chk("rst_m_data",  32'(m_data),  32'hA5);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    #1 aresetn = 1'b1;
    clk_en = 1'b1;

    // latency: single 8'h11, m_ready held high
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h11;
    #1 chk("lat_s_ready", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    chk("lat_c1_m_valid", 32'(m_valid), 32'd0);
    chk("lat_c1_count",   32'(count),   32'd1);
    tick();
    chk("lat_c2_m_valid", 32'(m_valid), 32'd0);
    tick();
    chk("lat_c3_m_valid", 32'(m_valid), 32'd1);
    chk("lat_c3_m_data",  32'(m_data),  32'h11);
    tick();
    chk("lat_c4_m_valid", 32'(m_valid), 32'd0);
    chk("lat_c4_count",   32'(count),   32'd0);

    // full / stall, then drain at full rate
    m_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      s_valid = 1'b1;
      s_data  = 8'(k);
      #1 chk($sformatf("fill_s_ready_%0d", k), 32'(s_ready), 32'd1);
      tick();
    end
    s_data = 8'h04;
    #1;
    chk("full_count",   32'(count),   32'd3);
    chk("full_s_ready", 32'(s_ready), 32'd0);
    chk("full_m_data",  32'(m_data),  32'h01);
    tick();
    chk("stall_count",  32'(count),   32'd3);
    chk("stall_m_data", 32'(m_data),  32'h01);
    m_ready = 1'b1;
    #1 chk("drain_s_ready", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    chk("drain_count_after_04", 32'(count), 32'd3);
    for (int k = 2; k <= 4; k++) begin
      chk($sformatf("drain_m_valid_%0d", k), 32'(m_valid), 32'd1);
      chk($sformatf("drain_m_data_%0d", k),  32'(m_data),  32'(k));
      tick();
    end
    chk("drain_empty_m_valid", 32'(m_valid), 32'd0);
    chk("drain_empty_count",   32'(count),   32'd0);

    // bubble collapse: only the output stage valid, downstream stalled
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h21;
    tick();
    s_valid = 1'b0;
    tick();
    tick();
    chk("bub_count1", 32'(count),  32'd1);
    chk("bub_m_data", 32'(m_data), 32'h21);
    s_valid = 1'b1;
    s_data  = 8'h22;
    #1 chk("bub_s_ready_22", 32'(s_ready), 32'd1);
    tick();
    s_data = 8'h23;
    #1 chk("bub_s_ready_23", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    chk("bub_count3", 32'(count), 32'd3);
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bub_drain_%0d", k), 32'(m_data), 32'(8'h21 + k));
      tick();
    end
    chk("bub_drain_empty", 32'(m_valid), 32'd0);

    // flush with count=2 and competing s_valid / m_ready
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h31;
    tick();
    s_data = 8'h32;
    tick();
    s_valid = 1'b0;
    tick();
    chk("fl_pre_count",  32'(count),  32'd2);
    chk("fl_pre_m_data", 32'(m_data), 32'h31);
    flush   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h33;
    m_ready = 1'b1;
    #1;
    chk("fl_s_ready", 32'(s_ready), 32'd0);
    chk("fl_m_valid", 32'(m_valid), 32'd0);
    tick();
    flush   = 1'b0;
    s_valid = 1'b0;
    chk("fl_count",   32'(count),   32'd0);
    chk("fl_m_valid_after", 32'(m_valid), 32'd0);
    chk("fl_m_data",  32'(m_data),  32'h31);
    tick();
    tick();
    tick();
    chk("fl_no_leak", 32'(m_valid), 32'd0);

    // asynchronous reset mid-stream, then a fresh stream
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h41;
    tick();
    s_data = 8'h42;
    tick();
    s_valid = 1'b0;
    chk("mr_pre_count", 32'(count), 32'd2);
    #2 aresetn = 1'b0;
    #1;
    chk("mr_count",   32'(count),   32'd0);
    chk("mr_m_data",  32'(m_data),  32'hA5);
    chk("mr_m_valid", 32'(m_valid), 32'd0);
    tick();
    aresetn = 1'b1;
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h51;
    tick();
    s_valid = 1'b0;
    tick();
    chk("mr_lat_c2", 32'(m_valid), 32'd0);
    tick();
    chk("mr_lat_c3_valid", 32'(m_valid), 32'd1);
    chk("mr_lat_c3_data",  32'(m_data),  32'h51);
    tick();
    chk("mr_end_count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stdmacro_dffe_pipe.md
STDMACRO_DFFE_PIPE -- requirements
Module: stdmacro_dffe_pipe

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and aresetn.
REQ-002 Parameter DFF_WIDTH, default 1, SHALL set the payload width in bits (>=1).
REQ-003 Parameter DFF_RESET_VALUE [DFF_WIDTH-1:0], default 'b0, SHALL set the reset value of every stage data register.
REQ-004 Parameter PIPE_DEPTH, default 2, SHALL set the number of register stages (>=1).
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 aresetn  input  1  asynchronous reset, active low; release is synchronous to clk upstream.
REQ-007 flush  input  1  synchronous clear of all stage valids.
REQ-008 s_valid  input  1  upstream payload valid.
REQ-009 s_ready  output  1  block accepts s_data this cycle.
REQ-010 s_data  input  DFF_WIDTH  upstream payload.
REQ-011 m_valid  output  1  output stage holds valid payload.
REQ-012 m_ready  input  1  downstream accepts m_data this cycle.
REQ-013 m_data  output  DFF_WIDTH  output stage payload.
REQ-014 count  output  $clog2(PIPE_DEPTH+1)  number of valid stages.

Function
REQ-015 Stages SHALL be indexed 0 (input side) to PIPE_DEPTH-1 (output side); each stage SHALL hold one valid bit v[i] and one data register d[i].
REQ-016 A transfer SHALL occur on the input when s_valid && s_ready, and on the output when m_valid && m_ready, sampled at the rising edge of clk.
REQ-017 Stage readiness SHALL be combinational: rdy[PIPE_DEPTH-1] = !v[PIPE_DEPTH-1] || m_ready; rdy[i] = !v[i] || rdy[i+1].
REQ-018 s_ready SHALL equal rdy[0] && !flush; m_valid SHALL equal v[PIPE_DEPTH-1] && !flush; m_data SHALL equal d[PIPE_DEPTH-1].
REQ-019 When rdy[i] is 1 and flush is 0, stage i SHALL load v[i] <= valid of stage i-1 (s_valid for i=0) and d[i] <= data of stage i-1 (s_data for i=0).
REQ-020 d[i] SHALL update only when rdy[i] is 1 and the incoming valid is 1; otherwise d[i] SHALL hold (enable-gated, no update on bubbles).
REQ-021 When rdy[i] is 0, v[i] and d[i] SHALL hold.
REQ-022 Bubbles SHALL collapse: an invalid stage SHALL accept from its predecessor even while downstream stages are stalled.
REQ-023 Latency from an input transfer to m_valid for that payload SHALL be PIPE_DEPTH cycles when no stall occurs.
REQ-024 Sustained throughput SHALL be one payload per cycle when m_ready is held 1, including when all stages are valid (full).
REQ-025 Full with m_ready=0 SHALL give s_ready=0 and all stages held; empty SHALL give m_valid=0 and s_ready=1 (flush=0).
REQ-026 flush=1 SHALL clear every v[i] at the next edge, leave every d[i] unchanged, and allow no input or output transfer that cycle.
REQ-027 flush SHALL take priority over any simultaneous s_valid or m_ready.
REQ-028 count SHALL equal the number of set v[i], registered alongside them, range 0..PIPE_DEPTH, with no wrap.
REQ-029 Payload order SHALL be preserved; no payload SHALL be duplicated or dropped except by flush or reset.

Reset
REQ-030 While aresetn=0, all v[i] SHALL be 0 and all d[i] SHALL be DFF_RESET_VALUE, asynchronously, regardless of clk.
REQ-031 During reset, m_valid=0, count=0, m_data=DFF_RESET_VALUE, and s_ready follows REQ-018 (1 if flush=0).
REQ-032 Reset asserted mid-operation SHALL discard all in-flight payloads; the first edge after release SHALL behave as from an empty pipe.

Verification (DFF_WIDTH=8, PIPE_DEPTH=3, DFF_RESET_VALUE=8'hA5)
REQ-033 Reset: aresetn=0 with clk stopped -> m_valid=0, count=0, m_data=8'hA5 immediately.
REQ-034 Latency: empty, m_ready=1, single 8'h11 at cycle 0 -> m_valid=1, m_data=8'h11 at cycle 3 only; count returns to 0 at cycle 4.
REQ-035 Full/stall: m_ready=0, inputs 8'h01,8'h02,8'h03,8'h04 -> first three accepted, count=3, s_ready=0, 8'h04 held upstream; raise m_ready -> outputs 01,02,03,04 in order, one per cycle, with no gap.
REQ-036 Bubble collapse: m_ready=0, v=001 (output stage only) -> two further inputs accepted on consecutive cycles, count=3.
REQ-037 Flush: count=2, flush=1 with s_valid=1, m_ready=1 -> no transfer, next cycle count=0, m_valid=0, m_data unchanged.
REQ-038 Reset mid-stream: aresetn=0 for one cycle while count=2 -> count=0, m_data=8'hA5; stream resumes with latency 3.
